// File: rtl/proc_rr_scheduler.sv
// -----------------------------------------------------------------------------
// proc_rr_scheduler
//
// Preemptive round-robin process scheduler that sits between the control unit
// and the PC register of the MIPS-based core. It drives the PC to load on every
// committed instruction. While the OS runs it follows the datapath. It
// dispatches up to NPROC user processes and preempts a process after QUANTUM
// committed instructions. On a switch it steers the PC through the per-process
// save-context and load-context routines. It remembers where each process
// should resume, and raises stop once every process has finished.
//
// Optional feature (macro name): PROCSCHED_STATS_EN
//   defined     : switch_count is a 16-bit wrapping count of completed
//                 RESTORE->RUN switches.
//   not defined : switch_count is tied to zero.
//
// Ports
//   clk          in   1      clock; every state update happens on the falling edge
//   reset        in   1      synchronous, active-high reset
//   active_mask  in   NPROC  bit i-1 set = process i present (sampled at dispatch only)
//   opcode       in   6      opcode of the instruction being committed
//   pc_write     in   1      commit strobe
//   next_pc      in   PC_W   sequential/branch PC from the datapath
//   new_pc       out  PC_W   PC to load
//   cur_proc     out  4      running process, 0 = OS or context routine
//   preempt      out  1      a user process is running under a quantum
//   in_switch    out  1      a save or restore routine is running
//   stop         out  1      all processes have finished
//   lcd_code     out  16     status code for the LCD
//   switch_count out  16     completed context switches (see macro above)
//
// Commit strobe semantics: a falling edge with pc_write=1 is one committed
// instruction. It is the only event that advances the FSM, the quantum
// counter, the done mask or the resume table. With pc_write=0 only lcd_code
// may change, to show a stall code for IN, OUT or PEND.
// -----------------------------------------------------------------------------
module proc_rr_scheduler #(
    parameter int NPROC       = 10,
    parameter int PC_W        = 32,
    parameter int QUANTUM     = 10,
    parameter int PROC_BASE   = 1,
    parameter int PROC_STRIDE = 100,
    parameter int SAVE_BASE   = 1192,
    parameter int LOAD_BASE   = 1194,
    parameter int CTX_STRIDE  = 4,
    parameter int OS_END_PC   = 1035
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NPROC-1:0]  active_mask,
    input  logic [5:0]        opcode,
    input  logic              pc_write,
    input  logic [PC_W-1:0]   next_pc,
    output logic [PC_W-1:0]   new_pc,
    output logic [3:0]        cur_proc,
    output logic              preempt,
    output logic              in_switch,
    output logic              stop,
    output logic [15:0]       lcd_code,
    output logic [15:0]       switch_count
);

    localparam logic [5:0] OP_SCHED = 6'b111110;
    localparam logic [5:0] OP_PEND  = 6'b111101;
    localparam logic [5:0] OP_HALT  = 6'b010000;
    localparam logic [5:0] OP_IN    = 6'b000101;
    localparam logic [5:0] OP_OUT   = 6'b000110;

    localparam logic [15:0] LCD_IN     = 16'd11;
    localparam logic [15:0] LCD_SWITCH = 16'd12;
    localparam logic [15:0] LCD_OUT    = 16'd13;
    localparam logic [15:0] LCD_DONE   = 16'd14;
    localparam logic [15:0] LCD_OS     = 16'd15;
    localparam logic [15:0] LCD_PEND   = 16'd16;

    // Process indices run 1..NPROC; index 0 means "no process".
    localparam int IDX_W = $clog2(NPROC + 1);
    // Quantum counter holds 0..QUANTUM-1.
    localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_SAVE,
        S_RESTORE,
        S_DONE
    } state_t;

    state_t               state;
    logic [NPROC-1:0]     done;
    logic [CNT_W-1:0]     cnt;
    // In SAVE: the process being saved. In RESTORE: the process being loaded.
    logic [IDX_W-1:0]     sel_idx;
    logic [PC_W-1:0]      resume [0:NPROC];

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // First not-done process strictly after prev, wrapping NPROC->1. It
    // returns prev only when prev is the sole survivor, and 0 when none remain.
    function automatic logic [IDX_W-1:0] pick_after(input logic [IDX_W-1:0] prev,
                                                    input logic [NPROC-1:0] dn);
        logic [IDX_W-1:0] hi;
        logic [IDX_W-1:0] lo;
        logic             hi_ok;
        logic             lo_ok;
        hi    = '0;
        lo    = '0;
        hi_ok = 1'b0;
        lo_ok = 1'b0;
        for (int j = 1; j <= NPROC; j++) begin
            if (!dn[j-1]) begin
                if (!hi_ok && (j > int'(prev))) begin
                    hi    = IDX_W'(j);
                    hi_ok = 1'b1;
                end
                if (!lo_ok) begin
                    lo    = IDX_W'(j);
                    lo_ok = 1'b1;
                end
            end
        end
        return hi_ok ? hi : lo;
    endfunction

    // base + (idx-1)*stride, evaluated entirely in PC_W bits.
    function automatic logic [PC_W-1:0] slot_addr(input int base, input int stride,
                                                  input logic [IDX_W-1:0] idx);
        return PC_W'(base) + PC_W'(idx - IDX_W'(1)) * PC_W'(stride);
    endfunction

    // More than one process still not done.
    function automatic logic many_left(input logic [NPROC-1:0] dn);
        int n;
        n = 0;
        for (int j = 0; j < NPROC; j++) begin
            if (!dn[j]) n++;
        end
        return n > 1;
    endfunction

    // Done-mask bit for process idx.
    function automatic logic [NPROC-1:0] slot_bit(input logic [IDX_W-1:0] idx);
        logic [NPROC-1:0] r;
        r = '0;
        for (int j = 1; j <= NPROC; j++) begin
            if (int'(idx) == j) r[j-1] = 1'b1;
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state decode
    // -------------------------------------------------------------------------
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] disp_idx;
    logic [NPROC-1:0] pend_done;
    logic [IDX_W-1:0] pend_next;
    logic [IDX_W-1:0] sw_next;
    logic             multi;
    logic             expire;
    logic             go_done;
    logic             restore_go;

    assign cur_idx   = cur_proc[IDX_W-1:0];
    assign disp_idx  = pick_after('0, ~active_mask);   // lowest present process
    assign pend_done = done | slot_bit(cur_idx);
    assign pend_next = pick_after(cur_idx, pend_done);
    assign sw_next   = pick_after(sel_idx, done);
    // With a single survivor the counter is frozen, so it is never preempted.
    assign multi     = many_left(done);
    assign expire    = multi && (cnt == CNT_W'(QUANTUM - 1));

    // HALT from anywhere, an empty dispatch, or the last PEND all end the run.
    assign go_done = pc_write && (state != S_DONE) &&
                     ((opcode == OP_HALT) ||
                      ((state == S_IDLE) && (opcode == OP_SCHED) && (active_mask == '0)) ||
                      ((state == S_RUN)  && (opcode == OP_PEND)  && (&pend_done)));

    assign restore_go = pc_write && (state == S_RESTORE) && (opcode == OP_SCHED);

    // -------------------------------------------------------------------------
    // Scheduler FSM and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(negedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            new_pc    <= '0;
            cur_proc  <= '0;
            preempt   <= 1'b0;
            in_switch <= 1'b0;
            stop      <= 1'b0;
            lcd_code  <= '0;
            done      <= '0;
            cnt       <= '0;
            sel_idx   <= '0;
            resume[0] <= '0;
            for (int j = 1; j <= NPROC; j++) begin
                resume[j] <= slot_addr(PROC_BASE, PROC_STRIDE, IDX_W'(j));
            end
        end else if (!pc_write) begin
            // Stall: only the LCD reacts, and never once the run has finished.
            if (state != S_DONE) begin
                case (opcode)
                    OP_IN:   lcd_code <= LCD_IN;
                    OP_OUT:  lcd_code <= LCD_OUT;
                    OP_PEND: lcd_code <= LCD_PEND;
                    default: ;
                endcase
            end
        end else if (go_done) begin
            state     <= S_DONE;
            stop      <= 1'b1;
            new_pc    <= PC_W'(OS_END_PC);
            lcd_code  <= LCD_DONE;
            preempt   <= 1'b0;
            in_switch <= 1'b0;
            cur_proc  <= '0;
            if ((state == S_IDLE) && (opcode == OP_SCHED)) done <= ~active_mask;
            if ((state == S_RUN) && (opcode == OP_PEND))   done <= pend_done;
        end else begin
            case (state)
                S_IDLE: begin
                    if (opcode == OP_SCHED) begin
                        done     <= ~active_mask;
                        new_pc   <= resume[disp_idx];
                        cur_proc <= 4'(disp_idx);
                        preempt  <= 1'b1;
                        cnt      <= '0;
                        lcd_code <= 16'(disp_idx);
                        state    <= S_RUN;
                    end else begin
                        new_pc   <= next_pc;
                        lcd_code <= LCD_OS;
                    end
                end

                S_RUN: begin
                    // Track the resume point on every commit, including the one
                    // that ends the slice, so the process restarts after it.
                    resume[cur_idx] <= next_pc;
                    if (opcode == OP_PEND) begin
                        // PEND takes priority over a simultaneous quantum expiry:
                        // the finished process needs no save, go straight to load.
                        done      <= pend_done;
                        sel_idx   <= pend_next;
                        new_pc    <= slot_addr(LOAD_BASE, CTX_STRIDE, pend_next);
                        cur_proc  <= '0;
                        preempt   <= 1'b0;
                        in_switch <= 1'b1;
                        cnt       <= '0;
                        lcd_code  <= LCD_SWITCH;
                        state     <= S_RESTORE;
                    end else if (expire) begin
                        sel_idx   <= cur_idx;
                        new_pc    <= slot_addr(SAVE_BASE, CTX_STRIDE, cur_idx);
                        cur_proc  <= '0;
                        preempt   <= 1'b0;
                        in_switch <= 1'b1;
                        cnt       <= '0;
                        lcd_code  <= LCD_SWITCH;
                        state     <= S_SAVE;
                    end else begin
                        new_pc   <= next_pc;
                        lcd_code <= 16'(cur_idx);
                        if (multi) cnt <= cnt + CNT_W'(1);
                    end
                end

                S_SAVE: begin
                    lcd_code <= LCD_SWITCH;
                    if (opcode == OP_SCHED) begin
                        sel_idx <= sw_next;
                        new_pc  <= slot_addr(LOAD_BASE, CTX_STRIDE, sw_next);
                        state   <= S_RESTORE;
                    end else begin
                        new_pc <= next_pc;
                    end
                end

                S_RESTORE: begin
                    if (restore_go) begin
                        cur_proc  <= 4'(sel_idx);
                        new_pc    <= resume[sel_idx];
                        preempt   <= 1'b1;
                        in_switch <= 1'b0;
                        cnt       <= '0;
                        lcd_code  <= 16'(sel_idx);
                        state     <= S_RUN;
                    end else begin
                        new_pc   <= next_pc;
                        lcd_code <= LCD_SWITCH;
                    end
                end

                default: ;  // S_DONE is absorbing until reset
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Switch statistics
    // -------------------------------------------------------------------------
`ifdef PROCSCHED_STATS_EN
    logic [15:0] sw_cnt;

    always_ff @(negedge clk) begin
        if (reset) begin
            sw_cnt <= '0;
        end else if (restore_go) begin
            sw_cnt <= sw_cnt + 16'd1;
        end
    end

    assign switch_count = sw_cnt;
`else
    assign switch_count = 16'd0;
`endif

endmodule

// File: tb/tb_proc_rr_scheduler.sv
module tb_proc_rr_scheduler;

  localparam int W = 55;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_SCHED = 6'b111110;
  localparam logic [5:0] OP_PEND  = 6'b111101;
  localparam logic [5:0] OP_HALT  = 6'b010000;
  localparam logic [5:0] OP_IN    = 6'b000101;
  localparam logic [5:0] OP_OUT   = 6'b000110;

  // clock / reset / inputs
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  active_mask = 4'b0000;
  logic [5:0]  opcode = OP_NOP;
  logic        pc_write = 1'b0;
  logic [31:0] next_pc = 32'd0;

  logic [31:0] new_pc;
  logic [3:0]  cur_proc;
  logic        preempt;
  logic        in_switch;
  logic        stop;
  logic [15:0] lcd_code;
  logic [15:0] switch_count;

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           total = 0;
  int           bad = 0;
  int           sw_exp = 0;

  always #5 clk = ~clk;

  proc_rr_scheduler #(
    .NPROC(4),
    .QUANTUM(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .active_mask(active_mask),
    .opcode(opcode),
    .pc_write(pc_write),
    .next_pc(next_pc),
    .new_pc(new_pc),
    .cur_proc(cur_proc),
    .preempt(preempt),
    .in_switch(in_switch),
    .stop(stop),
    .lcd_code(lcd_code),
    .switch_count(switch_count)
  );

  function automatic logic [W-1:0] e(input logic [31:0] pc, input logic [3:0] cur,
                                     input logic pre, input logic sw, input logic stp,
                                     input logic [15:0] lcd);
    return {pc, cur, pre, sw, stp, lcd};
  endfunction

  task automatic check_out();
    logic [W-1:0] exp;
    logic [W-1:0] obs;
    string        tag;
    exp = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {new_pc, cur_proc, preempt, in_switch, stop, lcd_code};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got pc=%0d cur=%0d pre=%0b sw=%0b stop=%0b lcd=%0d want pc=%0d cur=%0d pre=%0b sw=%0b stop=%0b lcd=%0d",
             tag, obs[54:23], obs[22:19], obs[18], obs[17], obs[16], obs[15:0],
             exp[54:23], exp[22:19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  // driver: drive after the rising edge, DUT updates on the falling edge,
  // sample 1 time unit later
  task automatic step(input string tag, input logic rst, input logic pw,
                      input logic [5:0] op, input logic [31:0] npc, input logic [W-1:0] exp);
    @(posedge clk);
    reset    = rst;
    pc_write = pw;
    opcode   = op;
    next_pc  = npc;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    #1;
    check_out();
  endtask

  task automatic check_sw(input string tag);
    logic [15:0] want;
`ifdef PROCSCHED_STATS_EN
    want = 16'(sw_exp);
`else
    want = 16'd0;
`endif
    total++;
    assert (switch_count === want) else begin
      bad++;
      $error("FAIL %s: got switch_count=%0d want %0d", tag, switch_count, want);
    end
  endtask

  initial begin
    logic [31:0] npc_r;

    // reset state
    step("reset_a", 1'b1, 1'b0, OP_NOP, 32'd0, e(0, 0, 0, 0, 0, 0));
    step("reset_b", 1'b1, 1'b0, OP_NOP, 32'd0, e(0, 0, 0, 0, 0, 0));
    sw_exp = 0;
    check_sw("sw_reset");

    // OS running, stalls only touch the LCD
    step("idle_commit", 1'b0, 1'b1, OP_NOP, 32'd7, e(7, 0, 0, 0, 0, 15));
    step("idle_stall_in", 1'b0, 1'b0, OP_IN, 32'd50, e(7, 0, 0, 0, 0, 11));
    step("idle_stall_out", 1'b0, 1'b0, OP_OUT, 32'd50, e(7, 0, 0, 0, 0, 13));
    step("idle_stall_pend", 1'b0, 1'b0, OP_PEND, 32'd50, e(7, 0, 0, 0, 0, 16));
    step("idle_sched_nowrite", 1'b0, 1'b0, OP_SCHED, 32'd50, e(7, 0, 0, 0, 0, 16));

    // dispatch proc1 of {1,3}, quantum 3
    active_mask = 4'b0101;
    step("dispatch_p1", 1'b0, 1'b1, OP_SCHED, 32'd50, e(1, 1, 1, 0, 0, 1));
    step("p1_run_a", 1'b0, 1'b1, OP_NOP, 32'd2, e(2, 1, 1, 0, 0, 1));
    step("p1_run_b", 1'b0, 1'b1, OP_NOP, 32'd3, e(3, 1, 1, 0, 0, 1));
    step("p1_expire", 1'b0, 1'b1, OP_NOP, 32'd4, e(1192, 0, 0, 1, 0, 12));
    active_mask = 4'b1111;  // must be ignored outside dispatch
    step("save_commit", 1'b0, 1'b1, OP_NOP, 32'd1193, e(1193, 0, 0, 1, 0, 12));
    step("save_sched", 1'b0, 1'b1, OP_SCHED, 32'd1194, e(1202, 0, 0, 1, 0, 12));
    step("restore_commit", 1'b0, 1'b1, OP_NOP, 32'd1203, e(1203, 0, 0, 1, 0, 12));
    step("restore_to_p3", 1'b0, 1'b1, OP_SCHED, 32'd1204, e(201, 3, 1, 0, 0, 3));
    sw_exp++;
    check_sw("sw_after_first");

    // proc3 slice, wrap back to proc1 at its saved PC
    step("p3_run_a", 1'b0, 1'b1, OP_NOP, 32'd202, e(202, 3, 1, 0, 0, 3));
    step("p3_run_b", 1'b0, 1'b1, OP_NOP, 32'd203, e(203, 3, 1, 0, 0, 3));
    step("p3_expire", 1'b0, 1'b1, OP_NOP, 32'd204, e(1200, 0, 0, 1, 0, 12));
    step("save_p3_sched", 1'b0, 1'b1, OP_SCHED, 32'd1201, e(1194, 0, 0, 1, 0, 12));
    step("resume_p1", 1'b0, 1'b1, OP_SCHED, 32'd1195, e(4, 1, 1, 0, 0, 1));
    sw_exp++;

    // proc1 slice, then proc3 resumes at its saved PC
    step("p1_run_c", 1'b0, 1'b1, OP_NOP, 32'd5, e(5, 1, 1, 0, 0, 1));
    step("p1_run_d", 1'b0, 1'b1, OP_NOP, 32'd6, e(6, 1, 1, 0, 0, 1));
    step("p1_expire2", 1'b0, 1'b1, OP_NOP, 32'd7, e(1192, 0, 0, 1, 0, 12));
    step("save_p1_sched", 1'b0, 1'b1, OP_SCHED, 32'd1193, e(1202, 0, 0, 1, 0, 12));
    step("resume_p3", 1'b0, 1'b1, OP_SCHED, 32'd1203, e(204, 3, 1, 0, 0, 3));
    sw_exp++;

    // stalls inside RUN do not count toward the quantum
    step("p3_nowrite", 1'b0, 1'b0, OP_NOP, 32'd999, e(204, 3, 1, 0, 0, 3));
    step("p3_stall_pend", 1'b0, 1'b0, OP_PEND, 32'd999, e(204, 3, 1, 0, 0, 16));
    step("p3_run_c", 1'b0, 1'b1, OP_NOP, 32'd205, e(205, 3, 1, 0, 0, 3));
    step("p3_run_d", 1'b0, 1'b1, OP_NOP, 32'd206, e(206, 3, 1, 0, 0, 3));
    // PEND on the expiring commit: straight to LOAD(1), no save
    step("p3_pend_expiring", 1'b0, 1'b1, OP_PEND, 32'd207, e(1194, 0, 0, 1, 0, 12));
    step("resume_p1_last", 1'b0, 1'b1, OP_SCHED, 32'd1195, e(7, 1, 1, 0, 0, 1));
    sw_exp++;
    check_sw("sw_after_four");

    // sole survivor is never preempted
    for (int i = 8; i <= 11; i++) begin
      step("p1_alone", 1'b0, 1'b1, OP_NOP, 32'(i), e(32'(i), 1, 1, 0, 0, 1));
    end
    step("p1_pend_last", 1'b0, 1'b1, OP_PEND, 32'd12, e(1035, 0, 0, 0, 1, 14));
    step("done_hold", 1'b0, 1'b1, OP_SCHED, 32'd13, e(1035, 0, 0, 0, 1, 14));
    step("done_stall", 1'b0, 0, OP_IN, 32'd13, e(1035, 0, 0, 0, 1, 14));
    check_sw("sw_in_done");

    // reset in the middle of SAVE
    step("reset_c", 1'b1, 1'b0, OP_NOP, 32'd0, e(0, 0, 0, 0, 0, 0));
    sw_exp = 0;
    active_mask = 4'b0011;
    step("dispatch_p1_b", 1'b0, 1'b1, OP_SCHED, 32'd0, e(1, 1, 1, 0, 0, 1));
    step("p1b_run_a", 1'b0, 1'b1, OP_NOP, 32'd2, e(2, 1, 1, 0, 0, 1));
    step("p1b_run_b", 1'b0, 1'b1, OP_NOP, 32'd3, e(3, 1, 1, 0, 0, 1));
    step("p1b_expire", 1'b0, 1'b1, OP_NOP, 32'd4, e(1192, 0, 0, 1, 0, 12));
    step("reset_in_save", 1'b1, 1'b1, OP_SCHED, 32'd1193, e(0, 0, 0, 0, 0, 0));
    check_sw("sw_after_reset");
    active_mask = 4'b0010;
    step("dispatch_p2", 1'b0, 1'b1, OP_SCHED, 32'd0, e(101, 2, 1, 0, 0, 2));

    // single process, 20 random commits, PC tracks datapath
    step("reset_d", 1'b1, 1'b0, OP_NOP, 32'd0, e(0, 0, 0, 0, 0, 0));
    active_mask = 4'b0001;
    step("dispatch_only_p1", 1'b0, 1'b1, OP_SCHED, 32'd0, e(1, 1, 1, 0, 0, 1));
    for (int i = 0; i < 20; i++) begin
      npc_r = 32'($urandom_range(0, 1000));
      step("single_track", 1'b0, 1'b1, OP_NOP, npc_r, e(npc_r, 1, 1, 0, 0, 1));
    end
    step("halt_in_run", 1'b0, 1'b1, OP_HALT, 32'd555, e(1035, 0, 0, 0, 1, 14));

    // no process present -> straight to DONE
    step("reset_e", 1'b1, 1'b0, OP_NOP, 32'd0, e(0, 0, 0, 0, 0, 0));
    active_mask = 4'b0000;
    step("empty_dispatch", 1'b0, 1'b1, OP_SCHED, 32'd0, e(1035, 0, 0, 0, 1, 14));

    // highest slot only, then HALT from IDLE
    step("reset_f", 1'b1, 1'b0, OP_NOP, 32'd0, e(0, 0, 0, 0, 0, 0));
    active_mask = 4'b1000;
    step("dispatch_p4", 1'b0, 1'b1, OP_SCHED, 32'd0, e(301, 4, 1, 0, 0, 4));
    step("reset_g", 1'b1, 1'b0, OP_NOP, 32'd0, e(0, 0, 0, 0, 0, 0));
    step("halt_in_idle", 1'b0, 1'b1, OP_HALT, 32'd9, e(1035, 0, 0, 0, 1, 14));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
